// File: rtl/obi_sram_responder.sv
// Single-port SRAM behind an OBI-style request/grant interface.
// Responses come out of a fixed Latency-deep pipeline, in accept order.
module obi_sram_responder #(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [6:0]  rdata_intg_o
);

  localparam int unsigned IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] SpanBytes = 33'(MemWords) * 33'd4;

  logic [31:0]         mem [MemWords];
  logic [31:0]         offset;
  logic                in_range;
  logic                accept;
  logic [IdxW-1:0]     idx;
  logic [31:0]         rd_word;
  logic [CntW-1:0]     outstanding;
  logic [Latency-1:0]  pipe_valid;
  logic [Latency-1:0]  pipe_err;
  logic [31:0]         pipe_data [Latency];

  // Offset is compared in 33 bits so a window reaching the top of the map cannot wrap.
  assign offset   = addr_i - BaseAddr;
  assign in_range = (addr_i >= BaseAddr) && ({1'b0, offset} < SpanBytes);
  assign idx      = offset[IdxW+1:2];

  assign gnt_o  = rst_ni & req_i & ~stall_i & (outstanding < CntW'(MaxOutstanding));
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read data is captured at accept, so later writes cannot disturb it in the pipe.
  always_comb begin
    rd_word = '0;
    if (accept && !we_i && in_range) rd_word = mem[idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < Latency; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & ~in_range;
      pipe_data[0]  <= rd_word;
      for (int i = 1; i < Latency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else if (accept && !rvalid_o) begin
      outstanding <= outstanding + CntW'(1);
    end else if (!accept && rvalid_o) begin
      outstanding <= outstanding - CntW'(1);
    end
  end

  assign rvalid_o     = pipe_valid[Latency-1];
  assign rdata_o      = rvalid_o ? pipe_data[Latency-1] : '0;
  assign err_o        = rvalid_o & pipe_err[Latency-1];
  assign rdata_intg_o = '0;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Bench for obi_sram_responder: a Latency=1 and a Latency=3/MaxOutstanding=2 instance,
// each checked against a reference memory and a response queue.
module tb_obi_sram_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          MW   = 4096;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [2];
  logic        gnt    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        stall  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic [6:0]  intg   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  resp_t       q0 [$];
  resp_t       q1 [$];
  logic [31:0] m0 [int];
  logic [31:0] m1 [int];

  obi_sram_responder #(.MemWords(MW), .BaseAddr(BASE), .Latency(1), .MaxOutstanding(2)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .stall_i(stall[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .rdata_intg_o(intg[0])
  );

  obi_sram_responder #(.MemWords(MW), .BaseAddr(BASE), .Latency(3), .MaxOutstanding(2)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .stall_i(stall[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .rdata_intg_o(intg[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    longint unsigned av;
    av = longint'(a);
    return (av >= longint'(BASE)) && (av < longint'(BASE) + 4 * MW);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] mread(input int d, input int w);
    if (d == 0) return m0.exists(w) ? m0[w] : 32'hxxxx_xxxx;
    return m1.exists(w) ? m1[w] : 32'hxxxx_xxxx;
  endfunction

  task automatic mwrite(input int d, input int w, input logic [3:0] b, input logic [31:0] wd);
    logic [31:0] v;
    v = mread(d, w);
    for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = wd[8*k +: 8];
    if (d == 0) m0[w] = v;
    else        m1[w] = v;
  endtask

  task automatic push(input int d, input resp_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic mon(input int d);
    resp_t r;
    int    n;
    n = (d == 0) ? q0.size() : q1.size();
    if (rvalid[d]) begin
      if (n == 0) begin
        chk($sformatf("unexpected_rvalid%0d", d), 32'd1, 32'd0);
      end else begin
        r = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rdata%0d", d), rdata[d], r.data);
        chk($sformatf("err%0d", d), {31'd0, err[d]}, {31'd0, r.err});
        chk($sformatf("resp_cycle%0d", d), cyc, r.due);
        chk($sformatf("intg%0d", d), {25'd0, intg[d]}, 32'd0);
      end
    end else begin
      chk($sformatf("idle_rdata%0d", d), rdata[d], 32'd0);
      chk($sformatf("idle_err%0d", d), {31'd0, err[d]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Drives one request and leaves req high after the accept edge; acc is the accept cycle.
  task automatic issue(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] wd, output int acc);
    int    n;
    resp_t r;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    n   = 0;
    acc = -1;
    @(negedge clk);
    while (!gnt[d] && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!gnt[d]) begin
      chk("gnt_timeout", 32'd0, 32'd1);
    end else begin
      acc    = cyc;
      r.err  = !in_range(a);
      r.due  = cyc + lat(d);
      r.data = (!w && in_range(a)) ? mread(d, widx(a)) : 32'd0;
      if (w && in_range(a)) mwrite(d, widx(a), b, wd);
      push(d, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    req[d] = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int          acc;
  int          c0;
  logic [31:0] rnd [8];
  logic        gnt_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  resp_t       r;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = '0; wdata[d] = '0; stall[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b1; req[1] = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt[0]}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt[1]}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid[0]}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid[1]}, 32'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst_n  = 1'b1;
    c0     = cyc;

    // Latency-1 instance: basic writes/reads, byte lanes, range edges
    issue(0, 1'b1, 4'hF, BASE, 32'hDEAD_BEEF, acc);
    chk("first_accept_cycle", acc, c0);
    issue(0, 1'b0, 4'hF, BASE, 32'd0, acc);
    issue(0, 1'b1, 4'b0001, BASE, 32'h0000_00AA, acc);
    issue(0, 1'b0, 4'h0, BASE, 32'd0, acc);
    idle(0, 2);
    issue(0, 1'b0, 4'hF, BASE + 32'h4000, 32'd0, acc);
    issue(0, 1'b1, 4'hF, BASE + 32'h4000, 32'h1234_5678, acc);
    issue(0, 1'b0, 4'hF, BASE, 32'd0, acc);
    issue(0, 1'b0, 4'hF, BASE - 32'd4, 32'd0, acc);
    issue(0, 1'b1, 4'hF, BASE + 32'h3FFF, 32'hCAFE_F00D, acc);
    issue(0, 1'b0, 4'hF, BASE + 32'h3FFC, 32'd0, acc);
    issue(0, 1'b1, 4'h0, BASE + 32'h3FFC, 32'hFFFF_FFFF, acc);
    issue(0, 1'b0, 4'hF, BASE + 32'h3FFD, 32'd0, acc);
    for (int i = 0; i < 8; i++) rnd[i] = $urandom;
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 4'hF, BASE + 32'(4 * (i + 2)), rnd[i], acc);
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 4'($urandom_range(1, 15)), BASE + 32'(4 * (i + 2)), $urandom, acc);
    for (int i = 7; i >= 0; i--) issue(0, 1'b0, 4'hF, BASE + 32'(4 * (i + 2)), 32'd0, acc);
    idle(0, 3);

    // Latency-3 instance: outstanding limit with req held high
    issue(1, 1'b1, 4'hF, BASE + 32'h10, 32'h1111_2222, acc);
    idle(1, 5);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = BASE + 32'h10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("hold_gnt_c%0d", k), {31'd0, gnt[1]}, {31'd0, gnt_pat[k]});
      if (gnt[1]) begin
        r.data = mread(1, widx(BASE + 32'h10));
        r.err  = 1'b0;
        r.due  = cyc + 3;
        push(1, r);
      end
      @(posedge clk); #1;
    end
    idle(1, 6);

    // Stall window with one response in flight
    issue(1, 1'b0, 4'hF, BASE + 32'h10, 32'd0, acc);
    stall[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_gnt_c%0d", k), {31'd0, gnt[1]}, 32'd0);
      @(posedge clk); #1;
    end
    stall[1] = 1'b0;
    idle(1, 4);

    // Reset with a read in flight: response must vanish, memory must persist
    issue(1, 1'b0, 4'hF, BASE + 32'h10, 32'd0, acc);
    req[1] = 1'b0;
    rst_n  = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rvalid_c%0d", k), {31'd0, rvalid[1]}, 32'd0);
      @(posedge clk); #1;
    end
    issue(1, 1'b0, 4'hF, BASE + 32'h10, 32'd0, acc);
    idle(1, 5);
    issue(0, 1'b0, 4'hF, BASE, 32'd0, acc);
    idle(0, 3);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
